// File: rtl/rom_prefetch_buffer.sv
// Sequential instruction prefetcher between a CPU fetch port and a ROM with a
// fixed one-cycle response latency. It streams ahead of the CPU into a small
// FIFO and redirects the stream whenever the CPU asks for a word it does not hold.
module rom_prefetch_buffer #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ack,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_stb,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_ack
);

    localparam int WAW = ADDR_WIDTH - 2;     // word-address width
    localparam int PW  = $clog2(DEPTH);      // FIFO pointer width
    localparam int CW  = PW + 1;             // count width, holds 0..DEPTH

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WAW-1:0]  pf_ptr_q, pf_ptr_d;       // next word to prefetch
    logic            issued_q, issued_d;       // a strobe went out last cycle
    logic [WAW-1:0]  issued_addr_q, issued_addr_d;
    logic [WAW-1:0]  fifo_addr_q [DEPTH];
    logic [WAW-1:0]  fifo_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];

    logic [WAW-1:0]  req_word;
    logic [CW-1:0]   occ;
    logic            hit, pending, redirect, stream_stb, push;
    logic            unused_addr_lsbs;

    // Byte-offset bits of the fetch address carry no information.
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    // Request classification, ROM strobe generation and next-state logic.
    // Reset gates every decision so the outputs read zero while rst is high.
    always_comb begin
        req_word   = cpu_addr[ADDR_WIDTH-1:2];
        // In-flight strobe counts against capacity; a same-cycle pop does not.
        occ        = count_q + CW'(issued_q);
        hit        = !rst && cpu_req && !flush && (count_q != '0)
                     && (fifo_addr_q[rd_ptr_q] == req_word);
        pending    = !rst && cpu_req && !flush && (count_q == '0)
                     && issued_q && (issued_addr_q == req_word);
        redirect   = !rst && cpu_req && !flush && !hit && !pending;
        stream_stb = !rst && !flush && !redirect && (state_q == S_STREAM)
                     && (occ < CW'(DEPTH));
        // Only a response to our own strobe that is not being discarded lands.
        push       = !rst && rom_ack && issued_q && !redirect && !flush;

        cpu_ack  = hit;
        cpu_data = hit ? fifo_data_q[rd_ptr_q] : '0;
        rom_stb  = redirect || stream_stb;
        rom_addr = redirect   ? {req_word, 2'b00} :
                   stream_stb ? {pf_ptr_q, 2'b00} : '0;

        state_d       = state_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        pf_ptr_d      = pf_ptr_q;
        fifo_addr_d   = fifo_addr_q;
        fifo_data_d   = fifo_data_q;
        issued_d      = rom_stb;
        issued_addr_d = rom_addr[ADDR_WIDTH-1:2];

        if (redirect) begin
            state_d  = S_STREAM;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pf_ptr_d = req_word + WAW'(1);
        end else if (flush) begin
            state_d  = S_IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (stream_stb) pf_ptr_d = pf_ptr_q + WAW'(1);
            if (push) begin
                fifo_addr_d[wr_ptr_q] = issued_addr_q;
                fifo_data_d[wr_ptr_q] = rom_data;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (hit) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(hit);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pf_ptr_q      <= '0;
            issued_q      <= 1'b0;
            issued_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pf_ptr_q      <= pf_ptr_d;
            issued_q      <= issued_d;
            issued_addr_q <= issued_addr_d;
            fifo_addr_q   <= fifo_addr_d;
            fifo_data_q   <= fifo_data_d;
        end
    end

endmodule

// File: tb/tb_rom_prefetch_buffer.sv
// Directed bench for rom_prefetch_buffer: a one-cycle-latency ROM model
// returns 0x1000_0000 | byte_address; every cycle the four CPU/ROM outputs are
// checked against hand-derived values.
module tb_rom_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] cpu_data;
    logic        cpu_ack;
    logic [14:0] rom_addr;
    logic        rom_stb;
    logic [31:0] rom_data;
    logic        rom_ack;

    logic        rom_ack_r  = 1'b0;
    logic [31:0] rom_data_r = '0;
    logic        inject     = 1'b0;   // forces a stray rom_ack

    int n_cmp = 0;
    int n_bad = 0;

    rom_prefetch_buffer #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .flush(flush), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .rom_addr(rom_addr), .rom_stb(rom_stb), .rom_data(rom_data),
        .rom_ack(rom_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [14:0] a);
        return 32'h1000_0000 | {17'd0, a};
    endfunction

    // ROM: registered response exactly one cycle after the strobe.
    always @(posedge clk) begin
        rom_ack_r  <= rom_stb;
        rom_data_r <= rom_word(rom_addr);
    end
    assign rom_ack  = rom_ack_r | inject;
    assign rom_data = inject ? 32'hDEAD_BEEF : rom_data_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, check all outputs, then advance past the next edge.
    task automatic cyc(input string tag, input logic e_ack, input logic [31:0] e_data,
                       input logic e_stb, input logic [14:0] e_addr);
        @(negedge clk);
        chk({tag, ".ack"},  {31'd0, cpu_ack}, {31'd0, e_ack});
        chk({tag, ".data"}, cpu_data, e_data);
        chk({tag, ".stb"},  {31'd0, rom_stb}, {31'd0, e_stb});
        chk({tag, ".addr"}, {17'd0, rom_addr}, {17'd0, e_addr});
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic [14:0] a, input logic f);
        cpu_req  = r;
        cpu_addr = a;
        flush    = f;
    endtask

    initial begin
        // Reset overrides request and flush.
        drv(1'b1, 15'h0010, 1'b1);
        cyc("rst", 1'b0, 32'h0, 1'b0, 15'h0);
        rst = 1'b0;
        drv(1'b0, 15'h0, 1'b0);
        cyc("idle", 1'b0, 32'h0, 1'b0, 15'h0);

        // Cold miss at 0: strobe now, pending next, ack two cycles later.
        drv(1'b1, 15'h0000, 1'b0);
        cyc("c0", 1'b0, 32'h0, 1'b1, 15'h0000);
        cyc("c1", 1'b0, 32'h0, 1'b1, 15'h0004);
        cyc("c2", 1'b1, 32'h1000_0000, 1'b1, 15'h0008);
        drv(1'b0, 15'h0, 1'b0);
        cyc("c3", 1'b0, 32'h0, 1'b1, 15'h000C);
        cyc("c4", 1'b0, 32'h0, 1'b1, 15'h0010);
        cyc("full5", 1'b0, 32'h0, 1'b0, 15'h0);
        cyc("full6", 1'b0, 32'h0, 1'b0, 15'h0);

        // Back-to-back sequential hits 0x04..0x1C; refill resumes after one pop.
        for (int i = 1; i <= 7; i++) begin
            drv(1'b1, 15'(4 * i), 1'b0);
            if (i == 1) cyc("seq", 1'b1, rom_word(15'(4 * i)), 1'b0, 15'h0);
            else        cyc("seq", 1'b1, rom_word(15'(4 * i)), 1'b1, 15'(4 * i + 12));
        end
        drv(1'b1, 15'h0020, 1'b0);
        cyc("hit20", 1'b1, 32'h1000_0020, 1'b1, 15'h002C);

        // Redirect to 0x4001; in-flight response for 0x2C is discarded.
        drv(1'b1, 15'h4001, 1'b0);
        cyc("rd0", 1'b0, 32'h0, 1'b1, 15'h4000);
        cyc("rd1", 1'b0, 32'h0, 1'b1, 15'h4004);
        cyc("rd2", 1'b1, 32'h1000_4000, 1'b1, 15'h4008);

        // Flush kills a would-be hit; the same address then misses.
        drv(1'b1, 15'h4004, 1'b1);
        cyc("fl0", 1'b0, 32'h0, 1'b0, 15'h0);
        drv(1'b0, 15'h0, 1'b0);
        cyc("fl_idle", 1'b0, 32'h0, 1'b0, 15'h0);
        drv(1'b1, 15'h4004, 1'b0);
        cyc("fl1", 1'b0, 32'h0, 1'b1, 15'h4004);
        cyc("fl2", 1'b0, 32'h0, 1'b1, 15'h4008);
        cyc("fl3", 1'b1, 32'h1000_4004, 1'b1, 15'h400C);

        // Address wrap at the top of the 15-bit space.
        drv(1'b1, 15'h7FF8, 1'b0);
        cyc("wr0", 1'b0, 32'h0, 1'b1, 15'h7FF8);
        cyc("wr1", 1'b0, 32'h0, 1'b1, 15'h7FFC);
        cyc("wr2", 1'b1, 32'h1000_7FF8, 1'b1, 15'h0000);
        drv(1'b1, 15'h7FFC, 1'b0);
        cyc("wr3", 1'b1, 32'h1000_7FFC, 1'b1, 15'h0004);
        drv(1'b1, 15'h0000, 1'b0);
        cyc("wr4", 1'b1, 32'h1000_0000, 1'b1, 15'h0008);
        drv(1'b1, 15'h0004, 1'b0);
        cyc("wr5", 1'b1, 32'h1000_0004, 1'b1, 15'h000C);

        // Fill up with a strobe in flight, then reset over a hitting request.
        drv(1'b0, 15'h0, 1'b0);
        cyc("pre0", 1'b0, 32'h0, 1'b1, 15'h0010);
        cyc("pre1", 1'b0, 32'h0, 1'b1, 15'h0014);
        rst = 1'b1;
        drv(1'b1, 15'h0008, 1'b0);
        cyc("mrst", 1'b0, 32'h0, 1'b0, 15'h0);
        rst = 1'b0;
        inject = 1'b1;
        drv(1'b0, 15'h0, 1'b0);
        cyc("stray", 1'b0, 32'h0, 1'b0, 15'h0);
        inject = 1'b0;
        drv(1'b1, 15'h0000, 1'b0);
        cyc("post0", 1'b0, 32'h0, 1'b1, 15'h0000);
        cyc("post1", 1'b0, 32'h0, 1'b1, 15'h0004);
        cyc("post2", 1'b1, 32'h1000_0000, 1'b1, 15'h0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
